spi_reg_responder: RTL and testbench
====================================

# spi_reg_responder

SPI mode-0 responder (slave) that sits on the far end of the SoC's `spi0` master port (`spi0_SCLK`/`spi0_MOSI`/`spi0_SS_n`/`spi0_MISO`). It implements a MAX3421E-style register-access protocol over a 32×8 internal register file. The block serves as an on-FPGA stand-in and loopback target for the USB-host SPI driver, and as a peripheral register bank.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sclk`, `spi_mosi` and `spi_ss_n`. Minimum 2.
- `IDLE_MISO`, default 1'b0: value driven on `spi_miso` while deselected.

Ports:
- `clk_clk` in 1: system clock. It is the only clock; the SPI pins are oversampled.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `spi_sclk` in 1: SPI clock from the master. Asynchronous to `clk_clk`.
- `spi_mosi` in 1: master-out data.
- `spi_ss_n` in 1: active-low chip select.
- `spi_miso` out 1: responder-out data.
- `spi_miso_oe` out 1: MISO output enable, high while selected.
- `status_in` in 8: byte shifted out during the command byte.
- `wr_strobe` out 1: one-cycle pulse per completed write-data byte.
- `wr_addr` out 5: register address, valid with `wr_strobe`.
- `wr_data` out 8: byte written, valid with `wr_strobe`.
- `frame_err` out 1: one-cycle pulse when `ss_n` deasserts mid-byte.

## Operation
- Clock, reset and synchronization:
  - Single clock is `clk_clk`. Reset is asynchronous and active-low on `reset_reset_n`.
  - SCLK, MOSI and SS_n pass through `SYNC_STAGES` flops before use.
  - Edges are detected on the synchronized SCLK and SS_n.
- Frame format, MSB first:
  - Byte 0 is the command: `[7:3]` register address, `[2]` ignored, `[1]` write=1/read=0, `[0]` ignored.
  - Bytes 1..N are data.
- FSM states:
  - IDLE: `ss_n` high. `miso_oe`=0. Bit counter cleared.
  - Synchronized `ss_n` falling edge: load `status_in` into the TX shifter, go to CMD.
  - CMD: MOSI sampled on each SCLK rise. MISO updated from TX shifter MSB on each SCLK fall.
  - After the 8th rise in CMD: latch address and direction, go to DATA. For a read, load `regs[addr]` into the TX shifter so it is available before the next fall.
  - DATA, write: on every 8th rise, `regs[addr] <= rx_byte`, and `wr_strobe` pulses with `wr_addr`/`wr_data`. The address does not increment; repeated bytes overwrite the same register.
  - DATA, read: on every 8th rise, reload the TX shifter with the current `regs[addr]`. MOSI bytes are ignored.
  - Any state, synchronized `ss_n` rise: return to IDLE. If the bit counter ≠ 0, pulse `frame_err`, and discard the partial byte with no register write.
- Bit counter: 3 bits, wraps 7→0 at each byte boundary.
- If the first SCLK fall in a frame arrives before the first rise, it still shifts out the loaded MSB with no underflow. The counter only advances on rises.
- Reset:
  - All registers are 0. FSM is in IDLE.
  - `spi_miso`=`IDLE_MISO`, `spi_miso_oe`=0, `wr_strobe`=0, `frame_err`=0, `wr_addr`=0, `wr_data`=0.
  - If `ss_n` is low when reset releases, the block waits for an `ss_n` rise before accepting a new frame. The partial frame is ignored and `frame_err` is not pulsed.
- Simultaneous SCLK edge and SS_n rise in the same cycle: the SS_n rise wins, and the edge is dropped.

## Timing
- Master requirements:
  - SCLK high and low phases each ≥ `SYNC_STAGES`+2 `clk_clk` periods (≥4 at default).
  - `ss_n` fall to first SCLK rise ≥ `SYNC_STAGES`+2 periods.
  - Last SCLK fall to `ss_n` rise ≥ 2 periods.
- MISO changes `SYNC_STAGES`+1 cycles after the pin-level SCLK fall.
- `wr_strobe` asserts `SYNC_STAGES`+2 cycles after the pin-level 8th rising edge and lasts exactly 1 cycle.
- A register read in the same cycle as a write to that register returns the old value. Reads and writes never overlap within one frame.

## Structure
- Package `spi_resp_pkg` holds:
  - the FSM state enum (IDLE, CMD, DATA);
  - `ADDR_W`=5, `NREGS`=32;
  - the command-bit positions `CMD_WR_BIT`=1, `CMD_ADDR_MSB`=7, `CMD_ADDR_LSB`=3.
- One sub-module, `sync_edge`: an N-stage synchronizer with rise/fall pulse outputs. It is instantiated for SCLK and SS_n; MOSI uses the synchronizer only.

## Test plan
- Write: `status_in`=0x5C, frame 0x1A,0xA5 at SCLK = clk/10.
  - MISO during byte 0 reads 0x5C.
  - `wr_strobe` pulses once with addr 3, data 0xA5.
  - `frame_err` stays 0.
- Read-back: frame 0x18,0x00 after the previous test → MISO byte 1 = 0xA5, no `wr_strobe`.
- Multi-byte write: 0x1A,0x11,0x22 → two strobes (0x11, then 0x22). A following read of reg 3 returns 0x22.
- Abort: `ss_n` rises after 5 bits of byte 1 of a write to reg 7 → `frame_err` 1-cycle pulse, no strobe, reg 7 still 0.
- Reset mid-frame: assert reset during byte 1 of a write, release with `ss_n` still low, clock 8 more bits.
  - No strobe.
  - `miso_oe`=0 until the next `ss_n` fall.
  - A new frame then works normally.
- Minimum timing: SCLK half-period = 4 clk, 4-byte read of reg 31 (preloaded 0xFF) → MISO bytes after the command are all 0xFF.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_resp_pkg;

  localparam int ADDR_W       = 5;
  localparam int NREGS        = 32;
  localparam int CMD_WR_BIT   = 1;
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Register address carried in a command byte.
  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/spi_reg_responder_sync_edge.sv
// N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,   // must be >= 2
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  // Shift the asynchronous input through the chain and keep one delayed copy for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= w_level;
    end
  end

  assign o_rise = w_level & ~r_prev;
  assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a 32x8 register file through a
// command byte (addr[7:3], write[1]) followed by data bytes.
// Handshake: wr_strobe is a one-cycle valid pulse with no ready; wr_addr/wr_data
// are meaningful only in the cycle wr_strobe is high.
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [7:0]        status_in,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err,
  output state_t            dbg_state
);

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic w_mosi;
  logic [7:0] w_rx_next;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx;
  logic [7:0]             r_tx;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_is_wr;
  logic                   r_wr_pend;
  logic [7:0]             r_pend_data;
  logic [7:0]             r_regs [NREGS];

  // SCLK idles low in mode 0.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_async (spi_sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // SS_n chain resets to "selected" so a select already active at reset
  // release yields no falling edge: the frame is only joined after a rise.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_async (spi_ss_n),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  // MOSI synchronizer, same depth as SCLK so a rise pulse lines up with its data bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_mosi_sync <= '0;
    else                r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_next = {r_rx[6:0], w_mosi};

  // Frame FSM: byte assembly, TX shifting, command decode and MISO drive.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_is_wr     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_pend_data <= '0;
      spi_miso    <= IDLE_MISO;
      spi_miso_oe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      r_wr_pend <= 1'b0;
      if (w_ss_rise) begin
        // Deselect wins over any simultaneous SCLK edge; a partial byte is dropped.
        r_state     <= ST_IDLE;
        r_bit_cnt   <= '0;
        spi_miso    <= IDLE_MISO;
        spi_miso_oe <= 1'b0;
        frame_err   <= (r_bit_cnt != 3'd0);
      end else if (r_state == ST_IDLE) begin
        if (w_ss_fall) begin
          r_state     <= ST_CMD;
          r_bit_cnt   <= '0;
          r_tx        <= status_in;
          spi_miso    <= status_in[7];
          spi_miso_oe <= 1'b1;
        end
      end else if (w_sclk_rise) begin
        r_rx      <= w_rx_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_tx      <= {r_tx[6:0], 1'b0};
        if (r_bit_cnt == 3'd7) begin
          if (r_state == ST_CMD) begin
            r_state <= ST_DATA;
            r_addr  <= cmd_addr(w_rx_next);
            r_is_wr <= w_rx_next[CMD_WR_BIT];
            if (!w_rx_next[CMD_WR_BIT]) r_tx <= r_regs[cmd_addr(w_rx_next)];
          end else if (r_is_wr) begin
            r_wr_pend   <= 1'b1;
            r_pend_data <= w_rx_next;
          end else begin
            r_tx <= r_regs[r_addr];
          end
        end
      end else if (w_sclk_fall) begin
        // A fall before the first rise just re-presents the loaded MSB.
        spi_miso <= r_tx[7];
      end
    end
  end

  // Register file commit and write-strobe output, one cycle after byte completion.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= r_wr_pend;
      if (r_wr_pend) begin
        r_regs[r_addr] <= r_pend_data;
        wr_addr        <= r_addr;
        wr_data        <= r_pend_data;
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: randomized SPI frames against a
// register-array reference model.
module tb_spi_reg_responder;
  import spi_resp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic [7:0] status = 8'h00;
  logic       miso, miso_oe, wr_strobe, frame_err;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  state_t     dbg_state;

  spi_reg_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .spi_sclk      (sclk),
    .spi_mosi      (mosi),
    .spi_ss_n      (ss_n),
    .spi_miso      (miso),
    .spi_miso_oe   (miso_oe),
    .status_in     (status),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_err     (frame_err),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model and scoreboard
  logic [7:0]  ref_regs [32];
  logic [12:0] exp_q [$];
  logic [12:0] obs_q [$];
  logic [7:0]  tx_b [16];
  logic [7:0]  rx_b [16];
  logic [7:0]  exp_rx [16];
  logic        chk_rx [16];
  int          exp_ferr;
  int          ferr_cnt = 0;
  int          ferr_long = 0;
  int          strb_long = 0;
  logic        prev_strb = 1'b0;
  logic        prev_ferr = 1'b0;

  // monitor: record strobes and error pulses, flag pulses longer than one cycle
  always @(negedge clk) begin
    if (wr_strobe) begin
      obs_q.push_back({wr_addr, wr_data});
      if (prev_strb) strb_long++;
    end
    if (frame_err) begin
      ferr_cnt++;
      if (prev_ferr) ferr_long++;
    end
    prev_strb = wr_strobe;
    prev_ferr = frame_err;
  end

  // driver: one SCLK period, MISO sampled at the rising edge
  task automatic spi_bit(input logic b, input int half, output logic m);
    mosi = b;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
  endtask

  // driver: full frame from tx_b; abort_bits >= 0 deselects after that many bits
  task automatic spi_xfer(input int nbytes, input int half, input int abort_bits);
    int  bits;
    logic m;
    bits = 0;
    @(negedge clk);
    ss_n = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      for (int k = 7; k >= 0; k--) begin
        if (!(abort_bits >= 0 && bits >= abort_bits)) begin
          spi_bit(tx_b[b][k], half, m);
          rx_b[b][k] = m;
          bits++;
        end
      end
    end
    repeat (half) @(negedge clk);
    ss_n = 1'b1;
    repeat (2 * half + 8) @(negedge clk);
  endtask

  // reference model: what a frame should do, from the protocol rules
  task automatic model_frame(input int nbytes, input int abort_bits);
    int       full;
    logic [4:0] a;
    logic     wr;
    a    = tx_b[0] >> 3;
    wr   = tx_b[0][1];
    full = (abort_bits < 0) ? nbytes : abort_bits / 8;
    exp_ferr = (abort_bits >= 0 && (abort_bits % 8) != 0) ? 1 : 0;
    for (int i = 0; i < 16; i++) chk_rx[i] = 1'b0;
    if (full >= 1) begin
      exp_rx[0] = status;
      chk_rx[0] = 1'b1;
    end
    for (int i = 1; i < full; i++) begin
      if (wr) begin
        ref_regs[a] = tx_b[i];
        exp_q.push_back({a, tx_b[i]});
      end else begin
        exp_rx[i] = ref_regs[a];
        chk_rx[i] = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (miso !== 1'b0)    begin n_err++; $display("FAIL reset_miso got %b exp 0", miso); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b exp 0", miso_oe); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe got %b exp 0", wr_strobe); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    n_vec++; if ({wr_addr, wr_data} !== 13'h0) begin n_err++; $display("FAIL reset_wr_bus got %h exp 0", {wr_addr, wr_data}); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
    for (int i = 0; i < 32; i++) ref_regs[i] = 8'h00;
  endtask

  task automatic test_write;
    status = 8'h5C; tx_b[0] = 8'h1A; tx_b[1] = 8'hA5;
    ferr_cnt = 0;
    model_frame(2, -1);
    spi_xfer(2, 5, -1);
    n_vec++; if (rx_b[0] !== 8'h5C) begin n_err++; $display("FAIL write_status got %h exp 5c", rx_b[0]); end
    n_vec++; if (obs_q.size() != 1 || obs_q[0] !== {5'd3, 8'hA5})
      begin n_err++; $display("FAIL write_strobe got n=%0d first=%h exp n=1 %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0, {5'd3, 8'hA5}); end
    n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL write_ferr got %0d exp 0", ferr_cnt); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_readback;
    tx_b[0] = 8'h18; tx_b[1] = 8'h00;
    model_frame(2, -1);
    spi_xfer(2, 5, -1);
    n_vec++; if (rx_b[1] !== exp_rx[1] || exp_rx[1] !== 8'hA5) begin n_err++; $display("FAIL readback got %h exp a5", rx_b[1]); end
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL readback_strobe got %0d exp 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_multi_write;
    tx_b[0] = 8'h1A; tx_b[1] = 8'h11; tx_b[2] = 8'h22;
    model_frame(3, -1);
    spi_xfer(3, 5, -1);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL multi_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL multi_strobe%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    tx_b[0] = 8'h18; tx_b[1] = 8'h00;
    model_frame(2, -1);
    spi_xfer(2, 5, -1);
    n_vec++; if (rx_b[1] !== 8'h22) begin n_err++; $display("FAIL multi_readback got %h exp 22", rx_b[1]); end
  endtask

  task automatic test_abort;
    tx_b[0] = 8'h3A; tx_b[1] = 8'hFF;
    ferr_cnt = 0; ferr_long = 0;
    model_frame(2, 13);
    spi_xfer(2, 5, 13);
    n_vec++; if (ferr_cnt !== exp_ferr || ferr_long !== 0) begin n_err++; $display("FAIL abort_ferr got %0d long %0d exp %0d", ferr_cnt, ferr_long, exp_ferr); end
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_strobe got %0d exp 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
    tx_b[0] = 8'h38; tx_b[1] = 8'h00;
    model_frame(2, -1);
    spi_xfer(2, 5, -1);
    n_vec++; if (rx_b[1] !== 8'h00) begin n_err++; $display("FAIL abort_reg7 got %h exp 00", rx_b[1]); end
  endtask

  task automatic test_reset_mid_frame;
    logic m;
    int   oe_bad;
    // give reg 4 a nonzero value that reset must clear
    tx_b[0] = 8'h22; tx_b[1] = 8'h77;
    model_frame(2, -1);
    spi_xfer(2, 5, -1);
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    ss_n = 1'b0;
    for (int k = 7; k >= 0; k--) spi_bit(tx_b[0][k], 5, m);
    for (int k = 7; k >= 5; k--) spi_bit(1'b1, 5, m);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref_regs[i] = 8'h00;
    ferr_cnt = 0;
    oe_bad = 0;
    for (int k = 0; k < 8; k++) begin
      spi_bit(k[0], 5, m);
      if (miso_oe !== 1'b0) oe_bad++;
    end
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++; if (oe_bad !== 0) begin n_err++; $display("FAIL rstmid_oe got %0d high samples exp 0", oe_bad); end
    n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_oe_after got %b exp 0", miso_oe); end
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rstmid_strobe got %0d exp 0", obs_q.size()); end
    n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL rstmid_ferr got %0d exp 0", ferr_cnt); end
    obs_q.delete();
    tx_b[0] = 8'h20; tx_b[1] = 8'h00;
    model_frame(2, -1);
    spi_xfer(2, 5, -1);
    n_vec++; if (rx_b[1] !== exp_rx[1]) begin n_err++; $display("FAIL rstmid_read got %h exp %h", rx_b[1], exp_rx[1]); end
  endtask

  task automatic test_min_timing;
    tx_b[0] = 8'hFA; tx_b[1] = 8'hFF;
    model_frame(2, -1);
    spi_xfer(2, 4, -1);
    obs_q.delete(); exp_q.delete();
    tx_b[0] = 8'hF8;
    for (int i = 1; i < 5; i++) tx_b[i] = 8'($urandom_range(0, 255));
    model_frame(5, -1);
    spi_xfer(5, 4, -1);
    for (int i = 1; i < 5; i++) begin
      n_vec++; if (rx_b[i] !== 8'hFF) begin n_err++; $display("FAIL min_timing byte%0d got %h exp ff", i, rx_b[i]); end
    end
  endtask

  task automatic test_random;
    int nb, half, ab;
    for (int f = 0; f < 24; f++) begin
      nb   = $urandom_range(2, 5);
      half = $urandom_range(4, 8);
      ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(9, nb * 8 - 1) : -1;
      status = 8'($urandom_range(0, 255));
      for (int i = 0; i < nb; i++) tx_b[i] = 8'($urandom_range(0, 255));
      ferr_cnt = 0; ferr_long = 0;
      model_frame(nb, ab);
      spi_xfer(nb, half, ab);
      for (int i = 0; i < nb; i++) if (chk_rx[i]) begin
        n_vec++; if (rx_b[i] !== exp_rx[i]) begin n_err++; $display("FAIL rand f%0d miso byte%0d got %h exp %h", f, i, rx_b[i], exp_rx[i]); end
      end
      n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand f%0d strobe_count got %0d exp %0d", f, obs_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand f%0d strobe%0d got %h exp %h", f, i, obs_q[i], exp_q[i]); end
      end
      n_vec++; if (ferr_cnt !== exp_ferr || ferr_long !== 0) begin n_err++; $display("FAIL rand f%0d ferr got %0d exp %0d", f, ferr_cnt, exp_ferr); end
      obs_q.delete(); exp_q.delete();
    end
    n_vec++; if (strb_long !== 0) begin n_err++; $display("FAIL strobe_width got %0d multi-cycle pulses exp 0", strb_long); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_multi_write();
    test_abort();
    test_reset_mid_frame();
    test_min_timing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
